// File: rtl/mem_io_pkg.sv
// Shared types for the memory/IO responder: scan FSM states and FIFO count sizing.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    RESP
  } scan_state_t;

  // Width that holds every count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Synchronous FIFO with registered count/full/empty; push when full and pop when
// empty are ignored.
module sync_fifo
  import mem_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: assigning a default before any branch keeps always_comb free of latches.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + CW'(1);
    else if (do_pop && !do_push) count_next = count - CW'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count_next;
      full   <= (count_next == CW'(DEPTH));
      empty  <= (count_next == '0);
    end
  end

  // NOTE: storage arrays are deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  assign pop_data = store[rd_ptr];

endmodule

// File: rtl/mem_io_responder.sv
// M-stage responder: data BRAM, UART TX byte FIFO and a 4-byte little-endian
// scan assembler, returning load/scan results to the W stage.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        LwM,
  input  logic        printM,
  input  logic        scanM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataW,
  output logic        wb_valid,
  output logic        stall_m,
  output logic        stall_w,
  output logic        req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TX_CW = count_width(TX_DEPTH);

  logic              do_lw;
  logic              do_sw;
  logic              do_print;
  logic              do_scan;
  logic [ADDR_W-1:0] word_addr;

  // Fixed priority: load > store > print > scan.
  assign do_lw     = LwM;
  assign do_sw     = MemWriteM & ~LwM;
  assign do_print  = printM & ~LwM & ~MemWriteM;
  assign do_scan   = scanM & ~LwM & ~MemWriteM & ~printM;
  assign word_addr = ALUResultM[ADDR_W+1:2];

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] ram_q;

  // Read-first single port; a store followed by a load lands one edge earlier.
  always_ff @(posedge clk) begin
    if (do_sw) ram[word_addr] <= WriteDataM;
    ram_q <= ram[word_addr];
  end

  logic [TX_CW-1:0] tx_count;
  logic             tx_full;
  logic             tx_empty;
  logic             print_blocked;

  // The registered count reflects the start of the cycle, so a same-cycle pop
  // cannot unblock a print.
  assign print_blocked = do_print & (tx_count >= TX_CW'(TX_DEPTH));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_print & ~print_blocked),
    .push_data (WriteDataM[7:0]),
    .pop       (tx_valid & tx_ready),
    .pop_data  (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_valid = ~tx_empty;

  scan_state_t state;
  logic [1:0]  byte_cnt;
  logic [31:0] shreg;
  logic [31:0] scan_word;
  logic        wb_q;
  logic        wb_from_ram;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      shreg       <= '0;
      scan_word   <= '0;
      wb_q        <= 1'b0;
      wb_from_ram <= 1'b0;
    end else begin
      wb_q        <= do_lw | (state == RESP);
      wb_from_ram <= do_lw;
      unique case (state)
        IDLE: begin
          if (do_scan) begin
            state    <= GATHER;
            byte_cnt <= '0;
          end
        end
        GATHER: begin
          if (rx_valid) begin
            shreg    <= {rx_data, shreg[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= RESP;
          end
        end
        RESP: begin
          scan_word <= shreg;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced to their reset values while reset is held.
  assign ReadDataW = reset ? '0 : (wb_from_ram ? ram_q : scan_word);
  assign wb_valid  = wb_q & ~reset;
  assign rx_ready  = (state == GATHER) & ~reset;
  assign stall_w   = rx_ready;
  assign stall_m   = ~reset & (print_blocked | (state == GATHER) |
                               ((state == IDLE) & do_scan));
  assign req_ready = (state == IDLE) & ~tx_full & ~reset;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table, directed multi-cycle
// sequences and a randomized run against a queue/array reference model.
module tb_mem_io_responder;

  localparam int ADDR_W   = 17;
  localparam int TX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, LwM, printM, scanM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataW;
  logic        wb_valid, stall_m, stall_w, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  mem_io_responder #(
    .ADDR_W   (ADDR_W),
    .TX_DEPTH (TX_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .LwM        (LwM),
    .printM     (printM),
    .scanM      (scanM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataW  (ReadDataW),
    .wb_valid   (wb_valid),
    .stall_m    (stall_m),
    .stall_w    (stall_w),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    LwM        = 1'b0;
    printM     = 1'b0;
    scanM      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  typedef struct {
    logic        lw;
    logic        sw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_wbv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [14];
  logic [7:0]  sbytes [4];
  logic [7:0]  got [$];
  logic [7:0]  txq [$];
  logic [31:0] mm [int];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_wbv;
    logic [31:0] exp_rd;
    logic        blocked;
    int          widx;
    int          r;

    // Store/load vectors; expected outputs are those seen in the row's own cycle.
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2,         1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h3,         1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h2};
    vecs[8]  = '{1'b1, 1'b0, 32'h0008_0000, 32'h0,         1'b1, 32'h3};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'h99,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h2};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h2};
    sbytes = '{8'h78, 8'h56, 8'h34, 8'h12};

    // Reset, with scan and print strobes held high to show they are ignored.
    idle_inputs();
    tx_ready = 1'b0;
    reset    = 1'b1;
    scanM    = 1'b1;
    printM   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ReadDataW", ReadDataW, 32'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_stall_m", stall_m, 1'b0);
    check("rst_stall_w", stall_w, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    idle_inputs();
    reset = 1'b0;
    tick();
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_tx_valid", tx_valid, 1'b0);

    // Vector table: store-then-load, back-to-back loads, wrap, load-over-store priority.
    for (int i = 0; i < 14; i++) begin
      LwM        = vecs[i].lw;
      MemWriteM  = vecs[i].sw;
      ALUResultM = vecs[i].addr;
      WriteDataM = vecs[i].data;
      #1;
      check($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].exp_wbv);
      if (vecs[i].exp_wbv) check($sformatf("vec%0d_ReadDataW", i), ReadDataW, vecs[i].exp_rd);
      check($sformatf("vec%0d_stall_m", i), stall_m, 1'b0);
      check($sformatf("vec%0d_req_ready", i), req_ready, 1'b1);
      tick();
    end
    idle_inputs();

    // Fill the TX FIFO with tx_ready low, then block the 17th print.
    for (int i = 0; i < TX_DEPTH; i++) begin
      printM     = 1'b1;
      WriteDataM = 32'hABCD_EF00 | (32'h41 + i);
      #1;
      check($sformatf("print%0d_stall_m", i), stall_m, 1'b0);
      if (i == 0) check("print_first_tx_valid", tx_valid, 1'b0);
      if (i == 1) begin
        check("print_latency_tx_valid", tx_valid, 1'b1);
        check("print_latency_tx_data", tx_data, 8'h41);
      end
      tick();
    end
    WriteDataM = 32'hABCD_EF51;
    #1;
    check("print_full_stall_m", stall_m, 1'b1);
    check("print_full_stall_w", stall_w, 1'b0);
    check("print_full_req_ready", req_ready, 1'b0);
    tick();
    got.delete();
    tx_ready = 1'b1;
    #1;
    check("print_pop_same_cycle_stall_m", stall_m, 1'b1);
    got.push_back(tx_data);
    tick();
    #1;
    check("print_unblocked_stall_m", stall_m, 1'b0);
    got.push_back(tx_data);
    tick();
    printM = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!tx_valid) break;
      got.push_back(tx_data);
      tick();
    end
    check("print_byte_count", got.size(), TX_DEPTH + 1);
    for (int i = 0; i < got.size() && i <= TX_DEPTH; i++)
      check($sformatf("print_order%0d", i), got[i], 8'h41 + 8'(i));
    tx_ready = 1'b0;

    // Scan with gaps between the bytes.
    scanM = 1'b1;
    #1;
    check("scan_idle_rx_ready", rx_ready, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b0;
      #1;
      check($sformatf("scan_gap%0d_stall_m", i), stall_m, 1'b1);
      check($sformatf("scan_gap%0d_stall_w", i), stall_w, 1'b1);
      check($sformatf("scan_gap%0d_rx_ready", i), rx_ready, 1'b1);
      tick();
      rx_data  = sbytes[i];
      rx_valid = 1'b1;
      #1;
      check($sformatf("scan_byte%0d_stall_m", i), stall_m, 1'b1);
      check($sformatf("scan_byte%0d_stall_w", i), stall_w, 1'b1);
      tick();
    end
    rx_valid = 1'b0;
    #1;
    check("scan_resp_stall_m", stall_m, 1'b0);
    check("scan_resp_stall_w", stall_w, 1'b0);
    check("scan_resp_rx_ready", rx_ready, 1'b0);
    check("scan_resp_wb_valid", wb_valid, 1'b0);
    tick();
    scanM = 1'b0;
    #1;
    check("scan_wb_valid", wb_valid, 1'b1);
    check("scan_ReadDataW", ReadDataW, 32'h1234_5678);
    tick();
    #1;
    check("scan_wb_valid_once", wb_valid, 1'b0);

    // Reset cancels a pending load result.
    LwM        = 1'b1;
    ALUResultM = 32'h0000_0100;
    tick();
    LwM   = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_cancel_wb_valid", wb_valid, 1'b0);
    check("rst_cancel_ReadDataW", ReadDataW, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_cancel_after_wb_valid", wb_valid, 1'b0);
    tick();

    // Reset in the middle of a scan, then a fresh scan.
    scanM = 1'b1;
    tick();
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tick();
    rx_data = 8'hBB;
    tick();
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_scan_stall_m", stall_m, 1'b0);
    check("rst_scan_stall_w", stall_w, 1'b0);
    check("rst_scan_rx_ready", rx_ready, 1'b0);
    check("rst_scan_req_ready", req_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rescan_idle_rx_ready", rx_ready, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_data  = (i == 0) ? 8'h01 : 8'h00;
      rx_valid = 1'b1;
      #1;
      check($sformatf("rescan_byte%0d_rx_ready", i), rx_ready, 1'b1);
      tick();
    end
    rx_valid = 1'b0;
    #1;
    check("rescan_resp_stall_m", stall_m, 1'b0);
    tick();
    scanM = 1'b0;
    #1;
    check("rescan_wb_valid", wb_valid, 1'b1);
    check("rescan_ReadDataW", ReadDataW, 32'h0000_0001);
    tick();

    // Randomized loads, stores and prints against the reference model.
    exp_wbv = 1'b0;
    exp_rd  = 32'h0;
    blocked = 1'b0;
    txq.delete();
    for (int c = 0; c < 300; c++) begin
      if (!blocked) begin
        LwM       = 1'b0;
        MemWriteM = 1'b0;
        printM    = 1'b0;
        ALUResultM = ($urandom & ~((32'd1 << (ADDR_W + 2)) - 1)) +
                     ((c < 8) ? c * 4 : $urandom_range(0, 7) * 4);
        WriteDataM = $urandom;
        if (c < 8) MemWriteM = 1'b1;
        else begin
          r = $urandom_range(0, 9);
          if (r < 4) LwM = 1'b1;
          if (r == 0 || (r >= 4 && r <= 6)) MemWriteM = 1'b1;
          if (r == 7 || r == 8) printM = 1'b1;
        end
      end
      tx_ready = ($urandom_range(0, 2) == 0);
      #1;
      widx    = int'((ALUResultM >> 2) % (32'd1 << ADDR_W));
      blocked = printM && !LwM && !MemWriteM && (txq.size() >= TX_DEPTH);
      check("rnd_wb_valid", wb_valid, exp_wbv);
      if (exp_wbv) check("rnd_ReadDataW", ReadDataW, exp_rd);
      check("rnd_stall_m", stall_m, blocked);
      check("rnd_stall_w", stall_w, 1'b0);
      check("rnd_req_ready", req_ready, txq.size() < TX_DEPTH);
      check("rnd_tx_valid", tx_valid, txq.size() != 0);
      if (txq.size() != 0) check("rnd_tx_data", tx_data, txq[0]);
      exp_wbv = LwM;
      if (LwM) exp_rd = mm[widx];
      else if (MemWriteM) mm[widx] = WriteDataM;
      if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
      if (printM && !LwM && !MemWriteM && !blocked) txq.push_back(WriteDataM[7:0]);
      tick();
    end

    // Drain whatever the random run left in the FIFO.
    idle_inputs();
    tx_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (txq.size() == 0) break;
      #1;
      check("drain_tx_valid", tx_valid, 1'b1);
      check("drain_tx_data", tx_data, txq[0]);
      void'(txq.pop_front());
      tick();
    end
    #1;
    check("drain_empty", txq.size(), 0);
    check("drain_tx_valid_low", tx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
